// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial link: the COM alignment symbol and receiver state encoding.
// The transmitter imports the same COM_SYMBOL so both ends agree on the idle pattern.
package serial_paralelo_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/serial_paralelo_com_detect.sv
// Combinational COM symbol comparator, shared by anything that needs to spot the idle pattern.
module serial_paralelo_com_detect #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] COM  = serial_paralelo_pkg::COM_SYMBOL
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_com
);

  assign is_com = (word == COM);

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: slides over the bit stream until COM is seen, confirms
// byte alignment with COM_COUNT aligned COMs, then emits one byte per WIDTH bit clocks.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM       = COM_SYMBOL,
  parameter int unsigned      COM_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned ComW = $clog2(COM_COUNT + 1);

  state_e            state_q, state_d;
  // The oldest stored bit would fall out of nw, so only WIDTH-1 history bits are kept.
  logic [WIDTH-2:0]  sr_q, sr_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ComW-1:0]   com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              active_q, active_d;

  logic [WIDTH-1:0]  nw;
  logic              is_com;
  logic              boundary;
  logic [CntW-1:0]   bit_cnt_inc;
  logic [ComW-1:0]   com_cnt_inc;

  assign nw          = {sr_q, data_in};
  assign sr_d        = nw[WIDTH-2:0];
  assign boundary    = (bit_cnt_q == CntW'(WIDTH - 1));
  assign bit_cnt_inc = boundary ? '0 : bit_cnt_q + CntW'(1);
  assign com_cnt_inc = com_cnt_q + ComW'(1);

  serial_paralelo_com_detect #(
    .WIDTH (WIDTH),
    .COM   (COM)
  ) u_com_detect (
    .word   (nw),
    .is_com (is_com)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      StSearch: begin
        if (is_com) begin
          bit_cnt_d = '0;
          if (COM_COUNT <= 1) begin
            com_cnt_d = ComW'(COM_COUNT);
            active_d  = 1'b1;
            state_d   = StActive;
          end else begin
            com_cnt_d = ComW'(1);
            state_d   = StAlign;
          end
        end
      end
      StAlign: begin
        bit_cnt_d = bit_cnt_inc;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == ComW'(COM_COUNT)) begin
              active_d = 1'b1;
              state_d  = StActive;
            end
          end else begin
            // A COM at another bit offset can only be picked up again by sliding search.
            com_cnt_d = '0;
            state_d   = StSearch;
          end
        end
      end
      StActive: begin
        bit_cnt_d = bit_cnt_inc;
        if (boundary) begin
          data_d   = nw;
          valid_d  = !is_com;
          strobe_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed link scenarios plus a random COM-heavy stream with
// resets and bit slips, checked every bit clock against a bit-history reference model.
module tb_serial_paralelo;

  localparam int          NCOM = 4;
  localparam logic [7:0]  C    = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  serial_paralelo #(
    .WIDTH     (8),
    .COM       (8'hBC),
    .COM_COUNT (NCOM)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #1 clk_32f = ~clk_32f;

  // Reference model: last 8 received bits, bit time since reset, and the bit time of the
  // COM that started the current alignment attempt (-1 while sliding).
  logic [7:0] m_w;
  int         m_t;
  int         m_anchor;
  bit         m_locked;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step(input logic b, input logic rst_n);
    if (!rst_n) begin
      m_w = '0; m_t = 0; m_anchor = -1; m_locked = 0;
      m_data = '0; m_valid = 0; m_strobe = 0;
      return;
    end
    m_t++;
    m_w      = {m_w[6:0], b};
    m_strobe = 0;
    if (m_anchor < 0) begin
      if (m_w == C) m_anchor = m_t;
    end else if ((m_t - m_anchor) % 8 == 0) begin
      if (m_locked) begin
        m_data   = m_w;
        m_valid  = (m_w != C);
        m_strobe = 1;
      end else if (m_w != C) begin
        m_anchor = -1;
      end else if ((m_t - m_anchor) / 8 == NCOM - 1) begin
        m_locked = 1;
      end
    end
  endtask

  task automatic step(input logic b);
    data_in = b;
    @(posedge clk_32f);
    model_step(b, reset);
    #1;
    check("data_out", 32'(data_out), 32'(m_data));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
    check("active", 32'(active), 32'(m_locked));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step(1'($urandom_range(0, 1)));
    reset = 1'b1;
  endtask

  logic [7:0] t3_data [6];
  logic       t3_valid [6];
  logic [7:0] rb;

  initial begin
    t3_data  = '{8'hFF, 8'hEE, 8'hDD, 8'hBC, 8'hCC, 8'hBB};
    t3_valid = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // 1: reset held with random data
    reset = 1'b0;
    for (int i = 0; i < 16; i++) step(1'($urandom_range(0, 1)));
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_active", 32'(active), 32'h0);

    // 2: first lock
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) send_byte(C);
    check("lock_before_4th", 32'(active), 32'h0);
    send_byte(C);
    check("lock_at_4th", 32'(active), 32'h1);
    send_byte(8'hFF);
    check("first_data", 32'(data_out), 32'hFF);
    check("first_valid", 32'(valid_out), 32'h1);
    check("first_strobe", 32'(byte_strobe), 32'h1);

    // 3: stream after lock
    for (int i = 0; i < 6; i++) begin
      send_byte(t3_data[i]);
      check("stream_data", 32'(data_out), 32'(t3_data[i]));
      check("stream_valid", 32'(valid_out), 32'(t3_valid[i]));
    end

    // 4: broken COM run must not lock
    pulse_reset();
    for (int i = 0; i < 3; i++) send_byte(C);
    send_byte(8'h55);
    check("broken_run", 32'(active), 32'h0);
    for (int i = 0; i < 3; i++) send_byte(C);
    check("relock_before", 32'(active), 32'h0);
    send_byte(C);
    check("relock", 32'(active), 32'h1);

    // 5: reset mid-byte while active
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)));
    reset = 1'b0;
    step(1'b1);
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_active", 32'(active), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(C);
    check("reacq_before", 32'(active), 32'h0);
    send_byte(C);
    check("reacq", 32'(active), 32'h1);

    // 6: offset lookalike enters alignment then falls back
    pulse_reset();
    send_byte(8'h5E);
    step(1'b0);
    send_byte(8'h00);
    check("lookalike", 32'(active), 32'h0);
    step(1'b1);
    for (int i = 0; i < 4; i++) send_byte(C);
    check("lookalike_relock", 32'(active), 32'h1);

    // Random COM-heavy traffic with occasional resets and bit slips
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) pulse_reset();
      else if (r < 7) step(1'($urandom_range(0, 1)));
      else begin
        rb = ($urandom_range(0, 9) < 5) ? C : 8'($urandom_range(0, 255));
        send_byte(rb);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
